// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: data width, instruction-ROM address width, reset PC, fetch FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned IMEM_ADDR_W = 14;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // BOOT covers the single cycle in which the first ROM read is in flight.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ifetch_perf.sv
// Fetch-stage performance counters: instructions advanced and cycles stalled.
// Latency: counts are registered, visible the cycle after the event.
// Backpressure: none; counts every qualifying cycle and wraps at 2^32.
module ifetch_perf
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            stall,
    input  logic            redirect_valid,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_stall_cnt
);

    // A redirect cycle is neither a fetch advance nor a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else if (run && !redirect_valid) begin
            if (stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end else begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, drives the ROM word address, presents inst/inst_pc/inst_valid.
// Latency: one cycle ROM read; redirect target shown the cycle after redirect_valid.
// Backpressure: stall holds inst/inst_pc by re-reading the held word. Optional IFETCH_PERF_CNT_EN adds counters.
module ifetch
    import cpu_pkg::*;
#(
    parameter int unsigned     ADDR_W   = IMEM_ADDR_W,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [XLEN-1:0]   imem_dout,
    output logic [XLEN-1:0]   inst,
    output logic [XLEN-1:0]   inst_pc,
`ifdef IFETCH_PERF_CNT_EN
    output logic              inst_valid,
    output logic [XLEN-1:0]   perf_fetch_cnt,
    output logic [XLEN-1:0]   perf_stall_cnt
`else
    output logic              inst_valid
`endif
);

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_pc_nxt;
    logic [XLEN-1:0] inst_pc_nxt;

    // ROM address: redirect target first, then the pending request, or the held word while stalled.
    always_comb begin
        imem_addr = req_pc[ADDR_W+1:2];
        if (redirect_valid) begin
            imem_addr = redirect_pc[ADDR_W+1:2];
        end else if (state == BOOT) begin
            imem_addr = req_pc[ADDR_W+1:2];
        end else if (stall) begin
            imem_addr = inst_pc[ADDR_W+1:2];
        end
    end

    // The ROM data already corresponds to inst_pc, so it passes straight through.
    assign inst       = imem_dout;
    assign inst_valid = (state == RUN);

    // Next-state: redirect beats stall; BOOT ignores stall; otherwise advance unless stalled.
    always_comb begin
        state_nxt   = state;
        req_pc_nxt  = req_pc;
        inst_pc_nxt = inst_pc;
        if (redirect_valid) begin
            state_nxt   = RUN;
            inst_pc_nxt = redirect_pc;
            req_pc_nxt  = redirect_pc + 32'd4;
        end else if (state == BOOT || !stall) begin
            state_nxt   = RUN;
            inst_pc_nxt = req_pc;
            req_pc_nxt  = req_pc + 32'd4;
        end
    end

    // State and PC registers; reset discards any in-flight fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BOOT;
            req_pc  <= RESET_PC;
            inst_pc <= RESET_PC;
        end else begin
            state   <= state_nxt;
            req_pc  <= req_pc_nxt;
            inst_pc <= inst_pc_nxt;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    ifetch_perf u_perf (
        .clk            (clk),
        .rst            (rst),
        .run            (state == RUN),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`endif

endmodule
